// File: rtl/omr_pkg.sv
// Shared constants and enumerations for the OMR sheet reader and its row classifier.
package omr_pkg;
    localparam int NUM_Q = 10;
    localparam int OPT_W = 4;
    localparam int ANS_W = NUM_Q * OPT_W;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        DRAIN   = 2'd2
    } omr_state_e;

    typedef enum logic [1:0] {
        ONEHOT = 2'd0,
        BLANK  = 2'd1,
        MULTI  = 2'd2
    } row_class_e;
endpackage

// File: rtl/omr_row_classifier.sv
// Combinational row check: classifies one scanned bubble row and returns the value
// to store (the row itself when exactly one bubble is marked, otherwise zero).
module omr_row_classifier
    import omr_pkg::*;
#(
    parameter int W = OPT_W
) (
    input  logic [W-1:0] row_in,
    output row_class_e   row_class,
    output logic [W-1:0] row_clean
);

    // Clearing the lowest set bit leaves zero only for a single-bit value.
    always_comb begin
        row_class = MULTI;
        row_clean = '0;
        if (row_in == '0) begin
            row_class = BLANK;
        end else if ((row_in & (row_in - W'(1))) == '0) begin
            row_class = ONEHOT;
            row_clean = row_in;
        end
    end

endmodule

// File: rtl/omr_sheet_reader.sv
// Packs scanned bubble rows into a per-sheet answer vector with validity mask and
// blank/multi counts, holding each completed sheet until the grader takes it.
module omr_sheet_reader #(
    parameter int NUM_Q = omr_pkg::NUM_Q,
    parameter int OPT_W = omr_pkg::OPT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   row_valid,
    input  logic [OPT_W-1:0]       row_data,
    input  logic                   row_last,
    output logic                   row_ready,
    output logic                   sheet_valid,
    input  logic                   sheet_ready,
    output logic [NUM_Q*OPT_W-1:0] student_answers,
    output logic [NUM_Q-1:0]       invalid_mask,
    output logic [3:0]             blank_count,
    output logic [3:0]             multi_count,
    output logic                   frame_err
);

    import omr_pkg::omr_state_e, omr_pkg::row_class_e, omr_pkg::CNT_W;
    import omr_pkg::COLLECT, omr_pkg::HOLD, omr_pkg::DRAIN;
    import omr_pkg::BLANK, omr_pkg::MULTI;

    localparam int AW = NUM_Q * OPT_W;
    localparam int QW = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
    localparam logic [QW-1:0] LAST_Q = QW'(NUM_Q - 1);

    omr_state_e       state_q, state_d;
    logic [QW-1:0]    q_cnt_q, q_cnt_d;
    logic [AW-1:0]    ans_q, ans_d;
    logic [NUM_Q-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] blank_q, blank_d;
    logic [CNT_W-1:0] multi_q, multi_d;
    logic             sheet_valid_q, sheet_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             row_accept;
    logic             clear_acc;
    row_class_e       row_class;
    logic [OPT_W-1:0] row_clean;

    omr_row_classifier #(
        .W(OPT_W)
    ) u_classifier (
        .row_in   (row_data),
        .row_class(row_class),
        .row_clean(row_clean)
    );

    assign row_ready = (state_q != HOLD) && !reset;

    // Rows shift in from the bottom so the first question ends up in the top nibble.
    always_comb begin
        state_d       = state_q;
        q_cnt_d       = q_cnt_q;
        ans_d         = ans_q;
        mask_d        = mask_q;
        blank_d       = blank_q;
        multi_d       = multi_q;
        sheet_valid_d = sheet_valid_q;
        frame_err_d   = 1'b0;
        clear_acc     = 1'b0;
        row_accept    = row_valid && row_ready;

        unique case (state_q)
            COLLECT: begin
                if (row_accept) begin
                    ans_d  = {ans_q[AW-OPT_W-1:0], row_clean};
                    mask_d = {mask_q[NUM_Q-2:0], (row_class == BLANK) || (row_class == MULTI)};
                    if (row_class == BLANK) begin
                        blank_d = blank_q + CNT_W'(1);
                    end
                    if (row_class == MULTI) begin
                        multi_d = multi_q + CNT_W'(1);
                    end
                    if (q_cnt_q == LAST_Q) begin
                        q_cnt_d = '0;
                        if (row_last) begin
                            state_d       = HOLD;
                            sheet_valid_d = 1'b1;
                        end else begin
                            state_d     = DRAIN;
                            frame_err_d = 1'b1;
                            clear_acc   = 1'b1;
                        end
                    end else if (row_last) begin
                        frame_err_d = 1'b1;
                        clear_acc   = 1'b1;
                    end else begin
                        q_cnt_d = q_cnt_q + QW'(1);
                    end
                end
            end
            HOLD: begin
                if (sheet_ready) begin
                    state_d       = COLLECT;
                    sheet_valid_d = 1'b0;
                    clear_acc     = 1'b1;
                end
            end
            DRAIN: begin
                // Overlong sheet: swallow rows silently until its last row goes by.
                if (row_accept && row_last) begin
                    state_d   = COLLECT;
                    clear_acc = 1'b1;
                end
            end
            default: begin
                state_d       = COLLECT;
                sheet_valid_d = 1'b0;
                clear_acc     = 1'b1;
            end
        endcase

        if (clear_acc) begin
            q_cnt_d = '0;
            ans_d   = '0;
            mask_d  = '0;
            blank_d = '0;
            multi_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= COLLECT;
            q_cnt_q       <= '0;
            ans_q         <= '0;
            mask_q        <= '0;
            blank_q       <= '0;
            multi_q       <= '0;
            sheet_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            q_cnt_q       <= q_cnt_d;
            ans_q         <= ans_d;
            mask_q        <= mask_d;
            blank_q       <= blank_d;
            multi_q       <= multi_d;
            sheet_valid_q <= sheet_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign sheet_valid     = sheet_valid_q;
    assign frame_err       = frame_err_q;
    assign student_answers = ans_q;
    assign invalid_mask    = mask_q;
    assign blank_count     = blank_q;
    assign multi_count     = multi_q;

endmodule

// File: tb/tb_omr_sheet_reader.sv
// Scoreboard bench for omr_sheet_reader: stimulus pushes expected sheets and frame
// errors into a queue, an independent monitor pops and compares them.
module tb_omr_sheet_reader;

    typedef logic [3:0] row_q_t[$];

    typedef struct {
        bit          is_sheet;
        logic [39:0] ans;
        logic [9:0]  mask;
        logic [3:0]  blank;
        logic [3:0]  multi;
        time         t;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        row_valid = 1'b0;
    logic [3:0]  row_data = 4'h0;
    logic        row_last = 1'b0;
    logic        sheet_ready = 1'b1;
    logic        row_ready;
    logic        sheet_valid;
    logic [39:0] student_answers;
    logic [9:0]  invalid_mask;
    logic [3:0]  blank_count;
    logic [3:0]  multi_count;
    logic        frame_err;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  sr_mode = 0;

    omr_sheet_reader #(
        .NUM_Q(10),
        .OPT_W(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .row_valid      (row_valid),
        .row_data       (row_data),
        .row_last       (row_last),
        .row_ready      (row_ready),
        .sheet_valid    (sheet_valid),
        .sheet_ready    (sheet_ready),
        .student_answers(student_answers),
        .invalid_mask   (invalid_mask),
        .blank_count    (blank_count),
        .multi_count    (multi_count),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: wait expired at %0t", name, $time);
    endtask

    // Reference: a sheet's answers are the one-hot rows placed question-first, every
    // other row contributes zero and is counted as blank or multi.
    function automatic ev_t model(input row_q_t rows);
        ev_t e;
        e.is_sheet = 1'b1;
        e.ans = '0;
        e.mask = '0;
        e.blank = '0;
        e.multi = '0;
        e.t = 0;
        for (int i = 0; i < 10; i++) begin
            int ones = $countones(rows[i]);
            if (ones == 1) begin
                e.ans = e.ans | (40'(rows[i]) << (4 * (9 - i)));
            end else begin
                e.mask = e.mask | (10'(1) << (9 - i));
                if (ones == 0) e.blank = e.blank + 4'd1;
                else e.multi = e.multi + 4'd1;
            end
        end
        return e;
    endfunction

    function automatic logic [3:0] rand_row();
        int r = $urandom_range(0, 9);
        logic [3:0] v;
        if (r < 6) begin
            v = 4'(1 << $urandom_range(0, 3));
        end else if (r < 8) begin
            v = 4'h0;
        end else begin
            v = 4'($urandom);
            while ($countones(v) < 2) v = 4'($urandom);
        end
        return v;
    endfunction

    task automatic send_row(input logic [3:0] d, input logic last);
        int   waited = 0;
        logic rdy;
        @(negedge clk);
        row_valid = 1'b1;
        row_data  = d;
        row_last  = last;
        forever begin
            #1;
            rdy = row_ready;
            @(posedge clk);
            if (rdy) break;
            waited++;
            if (waited > 100) begin
                reportTimeout("row_accept");
                break;
            end
        end
    endtask

    task automatic applyStimulus(input row_q_t rows, input int max_gap, input bit use_ovr,
                                 input ev_t ovr, input bit drop_after);
        int  n = rows.size();
        ev_t e;
        for (int i = 0; i < n; i++) begin
            int gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            repeat (gap) begin
                @(negedge clk);
                row_valid = 1'b0;
                row_data  = 4'($urandom);
                row_last  = 1'($urandom);
            end
            send_row(rows[i], i == n - 1);
            if ((n == 10 && i == 9)) begin
                e = use_ovr ? ovr : model(rows);
                e.t = $time;
                exp_q.push_back(e);
            end else if ((n < 10 && i == n - 1) || (n > 10 && i == 9)) begin
                e = '{is_sheet: 1'b0, ans: '0, mask: '0, blank: '0, multi: '0, t: $time};
                exp_q.push_back(e);
            end
        end
        if (drop_after) begin
            @(negedge clk);
            row_valid = 1'b0;
            row_last  = 1'b0;
        end
    endtask

    initial begin : sheet_ready_driver
        forever begin
            @(negedge clk);
            case (sr_mode)
                0: sheet_ready = 1'b1;
                1: sheet_ready = 1'($urandom);
                default: sheet_ready = 1'b0;
            endcase
        end
    end

    // Monitor: samples mid-cycle, pops an expectation whenever a sheet or frame error appears.
    initial begin : monitor
        bit  prev_valid;
        bit  prev_hs;
        ev_t cur;
        ev_t e;
        prev_valid = 1'b0;
        prev_hs = 1'b0;
        cur = '{is_sheet: 1'b0, ans: '0, mask: '0, blank: '0, multi: '0, t: 0};
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                prev_valid = 1'b0;
                prev_hs = 1'b0;
                continue;
            end
            checkOutput("row_ready_decode", row_ready, !sheet_valid);
            if (prev_hs) checkOutput("valid_drop_after_hs", sheet_valid, 0);
            if (frame_err) begin
                if (exp_q.size() == 0) begin
                    reportTimeout("unexpected_frame_err");
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("ferr_kind", e.is_sheet, 0);
                    checkOutput("ferr_latency", $time - e.t, 7);
                end
            end
            if (sheet_valid && (!prev_valid || prev_hs)) begin
                if (exp_q.size() == 0) begin
                    reportTimeout("unexpected_sheet");
                end else begin
                    cur = exp_q.pop_front();
                    checkOutput("sheet_kind", cur.is_sheet, 1);
                    checkOutput("sheet_latency", $time - cur.t, 7);
                end
            end
            if (sheet_valid) begin
                checkOutput("student_answers", student_answers, cur.ans);
                checkOutput("invalid_mask", invalid_mask, cur.mask);
                checkOutput("blank_count", blank_count, cur.blank);
                checkOutput("multi_count", multi_count, cur.multi);
            end
            prev_valid = sheet_valid;
            prev_hs = sheet_valid && sheet_ready;
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_answers"}, student_answers, 0);
        checkOutput({tag, "_mask"}, invalid_mask, 0);
        checkOutput({tag, "_blank"}, blank_count, 0);
        checkOutput({tag, "_multi"}, multi_count, 0);
        checkOutput({tag, "_sheet_valid"}, sheet_valid, 0);
        checkOutput({tag, "_frame_err"}, frame_err, 0);
        checkOutput({tag, "_row_ready"}, row_ready, 1);
    endtask

    initial begin : stimulus
        row_q_t s1, s2, short4, long12, r;
        ev_t    e1, e2, none;
        int     w;

        s1 = '{4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4, 4'h1, 4'h8, 4'h8, 4'h8};
        s2 = '{4'h1, 4'h2, 4'h0, 4'h4, 4'h5, 4'h4, 4'h1, 4'h8, 4'h8, 4'h8};
        short4 = '{4'h1, 4'h2, 4'h4, 4'h8};
        long12 = '{4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4, 4'h1, 4'h8, 4'h8, 4'h8, 4'h2, 4'h1};
        e1 = '{is_sheet: 1'b1, ans: 40'h1224441888, mask: 10'h000, blank: 4'd0, multi: 4'd0, t: 0};
        e2 = '{is_sheet: 1'b1, ans: 40'h1204041888, mask: 10'h0A0, blank: 4'd1, multi: 4'd1, t: 0};
        none = '{is_sheet: 1'b0, ans: '0, mask: '0, blank: '0, multi: '0, t: 0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #2;
        check_all_zero("after_reset");

        applyStimulus(s1, 0, 1'b1, e1, 1'b1);
        applyStimulus(s2, 0, 1'b1, e2, 1'b1);

        applyStimulus(short4, 0, 1'b0, none, 1'b1);
        applyStimulus(s1, 0, 1'b1, e1, 1'b1);

        applyStimulus(long12, 1, 1'b0, none, 1'b1);
        applyStimulus(s2, 0, 1'b1, e2, 1'b1);

        // Grader stalls while the scanner keeps offering the next sheet's first row.
        sr_mode = 2;
        applyStimulus(s1, 0, 1'b1, e1, 1'b0);
        fork
            applyStimulus(s2, 0, 1'b1, e2, 1'b1);
            begin
                w = 0;
                while (!sheet_valid && w < 200) begin
                    @(negedge clk);
                    #2;
                    w++;
                end
                if (!sheet_valid) reportTimeout("hold_wait");
                for (int k = 0; k < 5; k++) begin
                    checkOutput("hold_row_ready_low", row_ready, 0);
                    checkOutput("hold_row_valid_held", row_valid, 1);
                    @(negedge clk);
                    #2;
                end
                sr_mode = 0;
            end
        join

        for (int i = 0; i < 6; i++) send_row(s1[i], 1'b0);
        @(negedge clk);
        row_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #2;
        check_all_zero("mid_sheet_reset");
        applyStimulus(s1, 0, 1'b1, e1, 1'b1);

        sr_mode = 1;
        for (int n = 0; n < 40; n++) begin
            int kind = $urandom_range(0, 19);
            int len;
            if (kind < 14) len = 10;
            else if (kind < 17) len = $urandom_range(1, 9);
            else len = $urandom_range(11, 13);
            r = {};
            for (int i = 0; i < len; i++) r.push_back(rand_row());
            applyStimulus(r, 2, 1'b0, none, 1'b1);
        end

        sr_mode = 0;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/omr_sheet_reader.md
# omr_sheet_reader

Front-end packer for the OMR grader. Accepts one scanned bubble row per handshake: a 4-bit sample per question, 10 questions per sheet. It validates each row as one-hot and assembles the rows into the 40-bit `student_answers` vector that the grading machine consumes. It is the producer side of the answer-vector interface: it sits between the scanner stream and the grader and holds each completed sheet until the grader accepts it.

## Interface
Parameters:
- `NUM_Q`, 10, questions per sheet.
- `OPT_W`, 4, options per question (one bit per bubble).

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `row_valid`  in  1  scanner presents a row.
- `row_data`  in  OPT_W  bubble samples; bit3 = option D … bit0 = option A.
- `row_last`  in  1  marks the final row of a sheet.
- `row_ready`  out  1  reader can accept a row.
- `sheet_valid`  out  1  completed sheet available.
- `sheet_ready`  in  1  grader accepts the sheet.
- `student_answers`  out  NUM_Q*OPT_W  packed answers; question 1 in [39:36].
- `invalid_mask`  out  NUM_Q  bit (NUM_Q-1-i) set when question i+1 is blank or multi-marked.
- `blank_count`  out  4  number of rows equal to 0000.
- `multi_count`  out  4  number of rows with ≥2 bits set.
- `frame_err`  out  1  one-cycle pulse on a sheet framing error.

## Operation
- States: COLLECT, HOLD, DRAIN.
- A row is accepted when `row_valid & row_ready`.
- `row_ready` = 1 in COLLECT and DRAIN, 0 in HOLD, and 0 while `reset` is high.
- **COLLECT.** Each accepted row is written into slot `q_cnt` (0..9), shifted in MSB-first.
  - One-hot row: stored as-is.
  - Blank or multi-marked row: stored as 0000, the corresponding `invalid_mask` bit is set, and `blank_count` or `multi_count` increments.
- **Framing rules in COLLECT:**
  - Accept with `row_last=1` and `q_cnt<9`: discard the partial sheet, clear all accumulators, pulse `frame_err`, stay in COLLECT.
  - Accept with `q_cnt==9` and `row_last=1`: go to HOLD.
  - Accept with `q_cnt==9` and `row_last=0`: discard the sheet, pulse `frame_err`, go to DRAIN.
- **DRAIN.** Accept and discard rows until a row with `row_last=1` is accepted, then go to COLLECT with accumulators cleared. No further `frame_err` pulses.
- **HOLD.**
  - `sheet_valid=1`.
  - `student_answers`, `invalid_mask` and both counts stay stable.
  - On `sheet_valid & sheet_ready`: clear the accumulators and go to COLLECT.
- `sheet_ready` is ignored outside HOLD.
- Counts saturate naturally: the maximum is 10, which fits in 4 bits.
- `blank_count + multi_count` equals popcount(`invalid_mask`).

## Timing
- Reset values:
  - state = COLLECT, `q_cnt`=0.
  - `student_answers`=0, `invalid_mask`=0, counts=0.
  - `sheet_valid`=0, `frame_err`=0.
  - `row_ready`=1 on the first cycle after `reset` deasserts.
- Reset mid-sheet or in HOLD discards everything; nothing is emitted.
- `sheet_valid` rises the cycle after the 10th accept.
- Minimum sheet period is 11 cycles: 10 rows plus 1 HOLD cycle when `sheet_ready` is tied high.
- `frame_err` is registered and high for exactly one cycle, the cycle after the offending accept.
- `sheet_valid` drops the cycle after the sheet handshake. `row_ready` rises in that same cycle, so a row offered then is accepted.
- All outputs are registered except `row_ready`, which is a state decode.

## Structure
- Shared package `omr_pkg`:
  - constants `NUM_Q`, `OPT_W`, `ANS_W` (=40);
  - state enum {COLLECT, HOLD, DRAIN};
  - row-class enum {ONEHOT, BLANK, MULTI}.
- Sub-module `omr_row_classifier`: combinational. Takes a 4-bit row and returns its class plus the sanitized 4-bit value to store.
- Top level holds the FSM, `q_cnt`, the shift register, the mask and the counters.

## Test plan
- Rows 1,2,2,4,4,4,1,8,8,8 (hex nibbles), `row_last` on row 10, `sheet_ready`=1 -> `student_answers`=40'h1224441888, `invalid_mask`=0, counts 0/0, `sheet_valid` high for exactly 1 cycle.
- Same sheet with row 3=0000 and row 5=0101 -> `student_answers`=40'h1204041888, `invalid_mask`=10'h0A0, `blank_count`=1, `multi_count`=1.
- `row_last` asserted on row 4 -> `frame_err` pulses once, no `sheet_valid`; a following clean 10-row sheet is emitted correctly.
- 12 rows with `row_last` on row 12 -> `frame_err` once after row 10, rows 11-12 dropped, next sheet correct.
- `sheet_ready` held low for 5 cycles in HOLD while the scanner keeps `row_valid`=1 -> `row_ready`=0 and outputs stable throughout; the row is accepted the cycle after the handshake.
- `reset` pulsed after row 6 -> all outputs 0 the next cycle, then a full sheet is emitted with no residue from the partial one.
